// File: rtl/midi_tx_if.sv
// midi_tx_if: event handshake between a MIDI event source and midi_tx.
interface midi_tx_if;
  logic       midi_event_valid;
  logic [7:0] midi_command;
  logic [6:0] midi_parameter_1;
  logic [6:0] midi_parameter_2;
  logic       midi_event_ack;
  modport master (output midi_event_valid, midi_command, midi_parameter_1, midi_parameter_2, input midi_event_ack);
  modport slave (input midi_event_valid, midi_command, midi_parameter_1, midi_parameter_2, output midi_event_ack);
endinterface

// File: rtl/midi_tx.sv
// midi_tx: MIDI 8N1 serialiser for 1-3 byte messages; define MIDI_TX_RUNNING_STATUS_EN
// to omit a repeated channel status byte (running status).
module midi_tx #(
  parameter int CLK_FREQ  = 16000000,
  parameter int BAUD_RATE = 31250
) (
  input  logic      clk,
  input  logic      rst_n,
  midi_tx_if.slave  ev,
  output logic      serial_tx,
  output logic      busy
);
  localparam int BIT_CLKS = CLK_FREQ / BAUD_RATE;
  localparam int CW = $clog2(BIT_CLKS + 1);
  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;
  state_t        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [2:0]    bit_q, bit_d;
  logic [1:0]    idx_q, idx_d, last_q, last_d, last_full;
  logic [7:0]    cmd_q, cmd_d, cur_byte;
  logic [6:0]    p1_q, p1_d, p2_q, p2_d;
  logic [3:0]    hi;
  logic          ready_q, ack, tick, skip;
`ifdef MIDI_TX_RUNNING_STATUS_EN
  logic [7:0]    rs_q, rs_d;
  logic          chan;
`endif
  assign tick = cnt_q == CW'(BIT_CLKS - 1);
  // Index of the last byte to send; the first byte is index 0 unless running status skips it.
  always_comb begin
    hi = ev.midi_command[7:4];
    last_full = (hi == 4'hC || hi == 4'hD) ? 2'd1 :
                hi != 4'hF ? 2'd2 :
                ev.midi_command == 8'hF2 ? 2'd2 :
                (ev.midi_command == 8'hF1 || ev.midi_command == 8'hF3) ? 2'd1 : 2'd0;
`ifdef MIDI_TX_RUNNING_STATUS_EN
    chan = ev.midi_command[7] && hi != 4'hF;
    skip = chan && ev.midi_command == rs_q;
    rs_d = !ack ? rs_q :
           chan ? ev.midi_command :
           ev.midi_command[7:3] == 5'b11110 ? 8'h00 : rs_q;
`else
    skip = 1'b0;
`endif
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      bit_q   <= '0;
      idx_q   <= '0;
      last_q  <= '0;
      cmd_q   <= '0;
      p1_q    <= '0;
      p2_q    <= '0;
      ready_q <= 1'b0;
`ifdef MIDI_TX_RUNNING_STATUS_EN
      rs_q    <= '0;
`endif
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      bit_q   <= bit_d;
      idx_q   <= idx_d;
      last_q  <= last_d;
      cmd_q   <= cmd_d;
      p1_q    <= p1_d;
      p2_q    <= p2_d;
      ready_q <= 1'b1;
`ifdef MIDI_TX_RUNNING_STATUS_EN
      rs_q    <= rs_d;
`endif
    end
  end
  always_comb begin
    state_d = state_q;
    bit_d   = bit_q;
    idx_d   = idx_q;
    last_d  = last_q;
    cmd_d   = cmd_q;
    p1_d    = p1_q;
    p2_d    = p2_q;
    cnt_d   = (state_q == IDLE || tick) ? '0 : cnt_q + 1'b1;
    case (state_q)
      IDLE: if (ack) begin
        cmd_d   = ev.midi_command;
        p1_d    = ev.midi_parameter_1;
        p2_d    = ev.midi_parameter_2;
        last_d  = last_full;
        idx_d   = {1'b0, skip};
        state_d = ev.midi_command[7] ? START : IDLE;
      end
      START: if (tick) begin
        state_d = DATA;
        bit_d   = '0;
      end
      DATA: if (tick) begin
        bit_d   = bit_q + 1'b1;
        state_d = bit_q == 3'd7 ? STOP : DATA;
      end
      STOP: if (tick) begin
        state_d = idx_q == last_q ? IDLE : START;
        idx_d   = idx_q + 1'b1;
      end
      default: state_d = IDLE;
    endcase
  end
  always_comb begin
    cur_byte  = idx_q == 2'd0 ? cmd_q : idx_q == 2'd1 ? {1'b0, p1_q} : {1'b0, p2_q};
    ack       = ready_q && state_q == IDLE && ev.midi_event_valid;
    busy      = state_q != IDLE || (ack && ev.midi_command[7]);
    serial_tx = state_q == START ? 1'b0 : state_q == DATA ? cur_byte[bit_q] : 1'b1;
  end
  assign ev.midi_event_ack = ack;
endmodule

// File: tb/tb_midi_tx.sv
// tb_midi_tx: directed stimulus with a byte scoreboard fed by a serial-line monitor.
module tb_midi_tx;
  localparam int BIT = 32;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic serial_tx, busy;
  int checks = 0, failures = 0, cyc = 0, ack_total = 0;
  logic [7:0] exp_q[$];
  midi_tx_if bus();
  midi_tx #(.CLK_FREQ(BIT * 31250), .BAUD_RATE(31250)) dut (
    .clk(clk), .rst_n(rst_n), .ev(bus.slave), .serial_tx(serial_tx), .busy(busy)
  );
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  always @(negedge clk) if (bus.midi_event_ack) ack_total <= ack_total + 1;
  initial begin
    #1000000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end
  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask
  task automatic wait_n(input int n, inout bit ab);
    for (int i = 0; i < n && !ab; i++) begin
      @(negedge clk);
      if (!rst_n) ab = 1'b1;
    end
  endtask
  // Line monitor: decodes each frame mid-bit and compares against the scoreboard.
  initial begin
    bit ab;
    logic [7:0] b, e;
    forever begin
      @(negedge clk);
      if (rst_n && serial_tx === 1'b0) begin
        ab = 1'b0;
        wait_n(BIT / 2, ab);
        if (!ab) check("start_bit", serial_tx, 0);
        for (int i = 0; i < 8; i++) begin
          wait_n(BIT, ab);
          b[i] = serial_tx;
        end
        wait_n(BIT, ab);
        if (!ab) begin
          check("stop_bit", serial_tx, 1);
          if (exp_q.size() == 0) begin
            check("unexpected_byte", b, 9'h100);
          end else begin
            e = exp_q.pop_front();
            check("rx_byte", b, e);
          end
        end
      end
    end
  end
  task automatic push3(input logic [7:0] a, input logic [7:0] b, input logic [7:0] c);
    exp_q.push_back(a);
    exp_q.push_back(b);
    exp_q.push_back(c);
  endtask
  task automatic send(input logic [7:0] c, input logic [6:0] a, input logic [6:0] b);
    int ack_cyc;
    @(negedge clk);
    bus.midi_event_valid = 1'b1;
    bus.midi_command = c;
    bus.midi_parameter_1 = a;
    bus.midi_parameter_2 = b;
    #1;
    ack_cyc = -1;
    for (int i = 0; i < 40 * BIT && ack_cyc < 0; i++) begin
      if (bus.midi_event_ack) ack_cyc = cyc;
      else @(negedge clk);
    end
    check("ack_seen", ack_cyc >= 0, 1);
    @(posedge clk);
    #1;
    bus.midi_event_valid = 1'b0;
    bus.midi_command = 8'($urandom);
    bus.midi_parameter_1 = 7'($urandom);
    bus.midi_parameter_2 = 7'($urandom);
  endtask
  task automatic after_ack(input string tag, input int exp_clks);
    int n = 0;
    @(negedge clk);
    check({tag, "_start"}, serial_tx, 0);
    check({tag, "_ack_once"}, bus.midi_event_ack, 0);
    while (busy && n <= 40 * BIT) begin
      n++;
      @(negedge clk);
    end
    check(tag, n, exp_clks);
    check({tag, "_drain"}, exp_q.size(), 0);
  endtask
  initial begin
    int n, a0, acks0;
    int ac[3];
    bus.midi_event_valid = 1'b1;
    bus.midi_command = 8'h90;
    bus.midi_parameter_1 = 7'h3C;
    bus.midi_parameter_2 = 7'h64;
    repeat (3) @(negedge clk);
    check("rst_tx", serial_tx, 1);
    check("rst_busy", busy, 0);
    check("rst_ack", bus.midi_event_ack, 0);
    rst_n = 1'b1;
    #1;
    check("ack_before_edge", bus.midi_event_ack, 0);
    @(negedge clk);
    check("ack_first_cycle", bus.midi_event_ack, 1);
    check("busy_at_ack", busy, 1);
    push3(8'h90, 8'h3C, 8'h64);
    @(posedge clk);
    #1;
    bus.midi_event_valid = 1'b0;
    bus.midi_command = 8'h00;
    after_ack("noteon_len", 30 * BIT);
`ifdef MIDI_TX_RUNNING_STATUS_EN
    exp_q.push_back(8'h3E);
    exp_q.push_back(8'h00);
    send(8'h90, 7'h3E, 7'h00);
    after_ack("running_len", 20 * BIT);
`else
    push3(8'h90, 8'h3E, 8'h00);
    send(8'h90, 7'h3E, 7'h00);
    after_ack("repeat_len", 30 * BIT);
`endif
    exp_q.push_back(8'hC3);
    exp_q.push_back(8'h05);
    send(8'hC3, 7'h05, 7'h7F);
    after_ack("progchg_len", 20 * BIT);
    send(8'h45, 7'h11, 7'h22);
    check("discard_busy", busy, 0);
    n = 0;
    repeat (2 * BIT) begin
      @(negedge clk);
      if (!serial_tx || busy) n++;
    end
    check("discard_quiet", n, 0);
    push3(8'hB0, 8'h01, 8'h40);
    send(8'hB0, 7'h01, 7'h40);
    after_ack("cc1_len", 30 * BIT);
    exp_q.push_back(8'hF8);
    send(8'hF8, 7'h55, 7'h66);
    after_ack("clock_len", 10 * BIT);
`ifdef MIDI_TX_RUNNING_STATUS_EN
    exp_q.push_back(8'h07);
    exp_q.push_back(8'h10);
    send(8'hB0, 7'h07, 7'h10);
    after_ack("cc2_rs_len", 20 * BIT);
`else
    push3(8'hB0, 8'h07, 8'h10);
    send(8'hB0, 7'h07, 7'h10);
    after_ack("cc2_len", 30 * BIT);
`endif
    exp_q.push_back(8'hF6);
    send(8'hF6, 7'h00, 7'h00);
    after_ack("tune_len", 10 * BIT);
    push3(8'hB0, 8'h01, 8'h40);
    send(8'hB0, 7'h01, 7'h40);
    after_ack("cc3_len", 30 * BIT);
    exp_q.push_back(8'hF6);
    send(8'hF6, 7'h00, 7'h00);
    after_ack("tune2_len", 10 * BIT);
    push3(8'hB0, 8'h07, 8'h10);
    send(8'hB0, 7'h07, 7'h10);
    after_ack("cc4_len", 30 * BIT);
    push3(8'h80, 8'h40, 8'h40);
    send(8'h80, 7'h40, 7'h40);
    repeat (188) @(negedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    check("abort_tx", serial_tx, 1);
    check("abort_busy", busy, 0);
    exp_q.delete();
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    n = 0;
    repeat (40 * BIT) begin
      @(negedge clk);
      if (!serial_tx || busy) n++;
    end
    check("abort_quiet", n, 0);
    acks0 = ack_total;
    @(posedge clk);
    #1;
    bus.midi_event_valid = 1'b1;
    for (int k = 0; k < 3; k++) begin
      bus.midi_command = 8'h90 + 8'(k);
      bus.midi_parameter_1 = 7'h30 + 7'(k);
      bus.midi_parameter_2 = 7'h50 + 7'(k);
      push3(8'h90 + 8'(k), 8'h30 + 8'(k), 8'h50 + 8'(k));
      ac[k] = -1;
      for (int i = 0; i < 40 * BIT && ac[k] < 0; i++) begin
        @(negedge clk);
        if (bus.midi_event_ack) ac[k] = cyc;
      end
      check("b2b_ack_seen", ac[k] >= 0, 1);
      @(posedge clk);
      #1;
      if (k == 2) bus.midi_event_valid = 1'b0;
    end
    after_ack("b2b_last_len", 30 * BIT);
    a0 = ac[1] - ac[0];
    check("b2b_gap1", a0 >= 30 * BIT + 1 && a0 <= 30 * BIT + 2, 1);
    a0 = ac[2] - ac[1];
    check("b2b_gap2", a0 >= 30 * BIT + 1 && a0 <= 30 * BIT + 2, 1);
    check("b2b_acks", ack_total - acks0, 3);
    repeat (BIT) @(negedge clk);
    check("final_drain", exp_q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
